blocpu_serial_loader: RTL
=========================

Name: blocpu_serial_loader

Overview:
Serial-command controller that sequences blocpu_core from a host over UART. It accepts byte commands from async_receiver and writes instruction memory. It drives core reset, start and stop, returns status and replies through async_transmitter, and notifies the host when the core halts. It sits between the UART pair and the core in the FPGA top level, replacing bench-driven loading and start-up.

Parameters:
ADDR_W, 8, instruction-memory address width (max 8; the address byte is truncated to ADDR_W bits)
INSTR_W, 12, instruction width (max 16; the {hi,lo} data word is truncated to INSTR_W bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; all state and outputs take reset values on the next clk edge
rx_data  in  8  byte from async_receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to async_transmitter
tx_start  out  1  one-cycle send strobe
tx_busy  in  1  transmitter busy
imem_we  out  1  instruction-memory write enable, one-cycle pulse
imem_addr  out  ADDR_W  write address
imem_wdata  out  INSTR_W  write data
core_reset  out  1  core reset, level
core_start  out  1  one-cycle pulse; core sets running
core_stop  out  1  one-cycle pulse; core clears running
core_running  in  1  core running status

Behaviour:
- Reset values:
  - core_reset=1; core_start=0; core_stop=0
  - imem_we=0; imem_addr=0; imem_wdata=0
  - tx_start=0; tx_data=0
  - overrun flag=0; halt_pending=0; FSM=IDLE
- FSM states: IDLE, LD_ADDR, LD_HI, LD_LO, [LD_CSUM], WRITE, RESP, RESP_WAIT.
- IDLE commands, decoded on rx_valid:
  - 0x4C 'L': if core_running=1, reply 0x45 'E'; otherwise go to LD_ADDR.
  - 0x52 'R': core_reset<=0; pulse core_start next cycle; reply 0x4B 'K'.
  - 0x53 'S': pulse core_stop; reply 'K'.
  - 0x58 'X': core_reset<=1 and held; core_stop pulse; reply 'K'.
  - 0x3F '?': reply {5'b0, overrun, core_reset, core_running}; the overrun flag clears once that reply is issued.
  - any other byte: reply 'E'.
- Load sequence:
  - LD_ADDR captures addr; LD_HI captures hi; LD_LO captures lo.
  - WRITE: imem_we=1 for exactly one cycle, addr=addr[ADDR_W-1:0], data={hi,lo}[INSTR_W-1:0]; then reply 'K'.
  - Latency: imem_we asserts the cycle after the last data byte's rx_valid.
- Reply handshake:
  - RESP waits for tx_busy=0, then drives tx_start=1 for one cycle with tx_data stable.
  - RESP_WAIT waits one cycle for tx_busy to rise, then returns to IDLE.
  - tx_data holds its value until the next reply.
- Overrun: rx_valid seen in RESP or RESP_WAIT drops the byte and sets the sticky overrun flag. A partially received load is not corrupted, because bytes only arrive in load states.
- Halt notification:
  - A falling edge of core_running (registered compare) sets halt_pending.
  - In IDLE, halt_pending has priority over a new rx command in the same cycle: send 0x48 'H' and clear halt_pending. The rx byte in that cycle counts as overrun.
  - Falling edges caused by 'S' or 'X' also produce 'H'.
- Simultaneous 'R' while already running: core_start still pulses; reply 'K'.
- Reset mid-load or mid-reply: FSM aborts with no write and no tx_start, and core_reset=1.

Optional Feature:
BLOCPU_LOADER_CSUM_EN:
- Defined: after LD_LO, LD_CSUM receives one byte that must equal addr^hi^lo. On match, go to WRITE and reply 'K'. On mismatch, no write, reply 'E'.
- Undefined: LD_CSUM state and the checksum logic are absent; a load is exactly 4 bytes.

Decomposition:
- Package blocpu_loader_pkg:
  - FSM state enum
  - command byte constants (CMD_LOAD, CMD_RUN, CMD_STOP, CMD_RESET, CMD_STATUS)
  - reply constants (RSP_OK 0x4B, RSP_ERR 0x45, RSP_HALT 0x48)
- Natural sub-module: blocpu_loader_tx_ctrl (RESP/RESP_WAIT reply sender with tx_busy handshake), instantiated once.

Test Plan:
- Bytes 4C 05 01 2A -> one imem_we pulse, addr=5, wdata=12'h12A; tx 'K'. With CSUM_EN, append 2E -> same; append 00 -> no write, 'E'.
- 52 after reset -> core_reset 1->0, single core_start pulse, 'K'; then 4C -> 'E' while core_running=1, no write.
- Core drops core_running -> exactly one 'H' sent; 3F then returns 0x00 when the core is stopped with core_reset=0.
- Byte injected while tx_busy=1 during a reply -> byte ignored; next 3F returns bit2=1; a following 3F returns bit2=0.
- reset asserted after 4C 05 -> no imem_we, no tx_start; then 4C 00 00 07 writes addr 0 normally.
- 0x99 -> 'E'; 58 -> core_reset=1, core_stop pulse, 'K'.

Source files
------------

// File: rtl/blocpu_loader_pkg.sv
// Shared types and byte codes for the blocpu serial loader.
// Optional load checksum is enabled by defining BLOCPU_LOADER_CSUM_EN.
package blocpu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_HI,
        LD_LO,
`ifdef BLOCPU_LOADER_CSUM_EN
        LD_CSUM,
`endif
        WRITE,
        RESP,
        RESP_WAIT
    } loaderState_t;

    localparam logic [7:0] CMD_LOAD   = 8'h4C;
    localparam logic [7:0] CMD_RUN    = 8'h52;
    localparam logic [7:0] CMD_STOP   = 8'h53;
    localparam logic [7:0] CMD_RESET  = 8'h58;
    localparam logic [7:0] CMD_STATUS = 8'h3F;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_HALT = 8'h48;

    function automatic logic [7:0] statusByte(input logic overrun,
                                              input logic coreReset,
                                              input logic coreRunning);
        return {5'b0, overrun, coreReset, coreRunning};
    endfunction

endpackage

// File: rtl/blocpu_loader_tx_ctrl.sv
// Reply sender: while the loader sits in RESP, fires one tx_start as soon as the
// transmitter is idle and latches the reply byte onto tx_data until the next reply.
module blocpu_loader_tx_ctrl
    import blocpu_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inResp,
    input  logic [7:0] rspByte,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       sent
);

    // The loader leaves RESP on the same edge, so tx_start is a single-cycle pulse.
    assign sent = inResp & ~tx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= sent;
            if (sent) begin
                tx_data <= rspByte;
            end
        end
    end

endmodule

// File: rtl/blocpu_serial_loader.sv
// UART command controller for blocpu_core: loads instruction memory, drives core reset/start/stop,
// replies per command and reports core halts. Define BLOCPU_LOADER_CSUM_EN for a per-load checksum byte.
module blocpu_serial_loader
    import blocpu_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_reset,
    output logic               core_start,
    output logic               core_stop,
    input  logic               core_running
);

    loaderState_t state;
    logic [7:0]   addrReg;
    logic [7:0]   hiReg;
`ifdef BLOCPU_LOADER_CSUM_EN
    logic [7:0]   loReg;
`endif
    logic [7:0]   rspByte;
    logic         statusRsp;
    logic         overrun;
    logic         haltPending;
    logic         coreRunningQ;
    logic         startDly;
    logic         respSent;
    logic         runFall;

    assign runFall = coreRunningQ & ~core_running;

    blocpu_loader_tx_ctrl uTxCtrl (
        .clk      (clk),
        .reset    (reset),
        .inResp   (state == RESP),
        .rspByte  (rspByte),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .sent     (respSent)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addrReg      <= 8'h00;
            hiReg        <= 8'h00;
`ifdef BLOCPU_LOADER_CSUM_EN
            loReg        <= 8'h00;
`endif
            rspByte      <= 8'h00;
            statusRsp    <= 1'b0;
            overrun      <= 1'b0;
            haltPending  <= 1'b0;
            coreRunningQ <= 1'b0;
            startDly     <= 1'b0;
            core_reset   <= 1'b1;
            core_start   <= 1'b0;
            core_stop    <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
        end else begin
            coreRunningQ <= core_running;
            core_start   <= startDly;
            startDly     <= 1'b0;
            core_stop    <= 1'b0;
            imem_we      <= 1'b0;

            if (runFall) begin
                haltPending <= 1'b1;
            end
            // Status replies report overrun once; clear it when that reply actually goes out.
            if (respSent && statusRsp) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (haltPending) begin
                        rspByte     <= RSP_HALT;
                        statusRsp   <= 1'b0;
                        haltPending <= runFall;
                        state       <= RESP;
                        if (rx_valid) begin
                            overrun <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        statusRsp <= 1'b0;
                        state     <= RESP;
                        case (rx_data)
                            CMD_LOAD: begin
                                if (core_running) begin
                                    rspByte <= RSP_ERR;
                                end else begin
                                    state <= LD_ADDR;
                                end
                            end
                            CMD_RUN: begin
                                core_reset <= 1'b0;
                                startDly   <= 1'b1;
                                rspByte    <= RSP_OK;
                            end
                            CMD_STOP: begin
                                core_stop <= 1'b1;
                                rspByte   <= RSP_OK;
                            end
                            CMD_RESET: begin
                                core_reset <= 1'b1;
                                core_stop  <= 1'b1;
                                rspByte    <= RSP_OK;
                            end
                            CMD_STATUS: begin
                                rspByte   <= statusByte(overrun, core_reset, core_running);
                                statusRsp <= 1'b1;
                            end
                            default: rspByte <= RSP_ERR;
                        endcase
                    end
                end
                LD_ADDR: begin
                    if (rx_valid) begin
                        addrReg <= rx_data;
                        state   <= LD_HI;
                    end
                end
                LD_HI: begin
                    if (rx_valid) begin
                        hiReg <= rx_data;
                        state <= LD_LO;
                    end
                end
`ifdef BLOCPU_LOADER_CSUM_EN
                LD_LO: begin
                    if (rx_valid) begin
                        loReg <= rx_data;
                        state <= LD_CSUM;
                    end
                end
                LD_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == (addrReg ^ hiReg ^ loReg)) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_W'(addrReg);
                            imem_wdata <= INSTR_W'({hiReg, loReg});
                            state      <= WRITE;
                        end else begin
                            rspByte <= RSP_ERR;
                            state   <= RESP;
                        end
                    end
                end
`else
                LD_LO: begin
                    if (rx_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ADDR_W'(addrReg);
                        imem_wdata <= INSTR_W'({hiReg, rx_data});
                        state      <= WRITE;
                    end
                end
`endif
                WRITE: begin
                    rspByte <= RSP_OK;
                    state   <= RESP;
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                end
                RESP: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (respSent) begin
                        state <= RESP_WAIT;
                    end
                end
                RESP_WAIT: begin
                    // One cycle for the transmitter to raise tx_busy before the next reply can start.
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
